ecc_operand_loader: RTL and testbench
=====================================

// Module: ecc_operand_loader
// PURPOSE
//  Upstream stage of the ECC scalar-multiply core. Deserialises the 4-bit nibble streams
//  for a, prime, k, Px, Py into 32-bit operands, MSB nibble first, and range-checks them.
//  Presents a valid operand set to the core over a valid/ready handshake.
//  Invalid sets are dropped and flagged with an error pulse.
// PARAMETERS
//  NIBBLE_W    4   width of each serial input lane
//  SIZE        32  operand width; must be a multiple of NIBBLE_W
//  NUM_NIB     SIZE/NIBBLE_W (8)  nibbles per operand (derived, do not override)
// PORTS
//  clk         in   1     clock, rising edge
//  reset       in   1     synchronous, active-high
//  i_start     in   1     frame start; the cycle it is high carries nibble 0 (MSB)
//  i_a         in   4     curve coefficient a nibble
//  i_prime     in   4     field prime nibble
//  i_k         in   4     scalar k nibble
//  i_px        in   4     point X nibble
//  i_py        in   4     point Y nibble
//  i_ready     in   1     core accepts operand set
//  o_a         out  32    assembled a (meaningful only while o_valid)
//  o_prime     out  32    assembled prime
//  o_k         out  32    assembled k
//  o_px        out  32    assembled Px
//  o_py        out  32    assembled Py
//  o_valid     out  1     operand set valid, held until accepted
//  o_busy      out  1     high whenever state != IDLE
//  o_err       out  1     one-cycle pulse: frame rejected
//  o_err_code  out  2     reason for last rejection; 0 = none
// BEHAVIOUR
//  Reset (sync): state=IDLE, nibble count=0, all five words=0, o_valid=0, o_err=0, o_err_code=0.
//   Reset has priority in every state, including mid-LOAD and HOLD; a partial frame is discarded.
//  Each shift register updates as word <= {word[SIZE-5:0], nibble}; all five lanes shift together.
//  FSM:
//   IDLE : if i_start, shift in nibble 0, cnt<=1, go to LOAD; else hold all registers.
//   LOAD : shift every cycle, cnt++. On the edge that shifts nibble NUM_NIB-1, go to CHECK.
//          i_start is ignored in this state.
//   CHECK: one cycle. Evaluate checks on the assembled words, highest priority first:
//          code 1: prime==0 or prime[0]==0 (even)
//          code 2: px>=prime or py>=prime (unsigned)
//          code 3: k==0
//          On any error: o_err<=1 for 1 cycle, o_err_code<=code, go to IDLE.
//          Otherwise: o_valid<=1, o_err_code<=0, go to HOLD.
//   HOLD : o_valid=1 and all words frozen. On o_valid&&i_ready, o_valid<=0 and go to IDLE.
//          i_start is ignored, including in the accept cycle.
//  Timing: i_start sampled at edge E0 -> nibbles sampled E0..E7 -> CHECK evaluated at E8
//   -> o_valid high from E8+. If i_ready is already high, accepted at E9.
//  o_err_code holds until the next CHECK or reset. Words keep their contents after reject/accept.
//  o_valid never falls without a handshake (except on reset). o_valid and o_err are never high together.
// TESTING
//  1 Nominal: a=2, prime=0x11, k=2, Px=5, Py=1, i_ready=1 -> o_valid from E8 to E9 only; words exact; o_err=0.
//  2 MSB order: prime nibbles F,F,F,F,F,F,F,B -> o_prime=0xFFFFFFFB; Px=0x12345678 built from nibbles 1..8.
//  3 Backpressure: i_ready=0 for 20 cycles with i_start pulses -> o_valid held, words stable, no reload;
//    raise i_ready -> o_valid drops next edge; o_busy then low.
//  4 Rejects: prime=0x10 -> o_err pulse, code 1. prime=0x11 with Px=0x11 -> code 2.
//    k=0 -> code 3. prime even with k=0 -> code 1 (priority). No o_valid in any of these.
//  5 Reset after nibble 4 -> next cycle all outputs 0, o_busy=0; a fresh frame then loads exactly as in 1.
//  6 Back-to-back: i_start asserted in the accept cycle -> ignored; i_start one cycle later -> new frame accepted.

Source files
------------

// File: rtl/ecc_operand_loader.sv
// Operand front end for the ECC scalar-multiply core: deserialises five nibble lanes
// MSB-first into SIZE-bit words, range-checks the set, and offers it over valid/ready.
module ecc_operand_loader #(
    parameter  int NIBBLE_W = 4,
    parameter  int SIZE     = 32,
    localparam int NUM_NIB  = SIZE / NIBBLE_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_start,
    input  logic [NIBBLE_W-1:0] i_a,
    input  logic [NIBBLE_W-1:0] i_prime,
    input  logic [NIBBLE_W-1:0] i_k,
    input  logic [NIBBLE_W-1:0] i_px,
    input  logic [NIBBLE_W-1:0] i_py,
    input  logic                i_ready,
    output logic [SIZE-1:0]     o_a,
    output logic [SIZE-1:0]     o_prime,
    output logic [SIZE-1:0]     o_k,
    output logic [SIZE-1:0]     o_px,
    output logic [SIZE-1:0]     o_py,
    output logic                o_valid,
    output logic                o_busy,
    output logic                o_err,
    output logic [1:0]          o_err_code
);

    localparam int CNT_W     = $clog2(NUM_NIB + 1);
    localparam int NUM_LANES = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               valid_reg;
    logic               err_reg;
    logic [1:0]         err_code_reg;
    logic               shift_en;
    logic [1:0]         chk_code;
    logic [NIBBLE_W-1:0] lane_nib [NUM_LANES];
    logic [SIZE-1:0]    prime_w;
    logic [SIZE-1:0]    k_w;
    logic [SIZE-1:0]    px_w;
    logic [SIZE-1:0]    py_w;

    assign lane_nib[0] = i_a;
    assign lane_nib[1] = i_prime;
    assign lane_nib[2] = i_k;
    assign lane_nib[3] = i_px;
    assign lane_nib[4] = i_py;

    // All lanes move in lock-step; words are frozen outside IDLE-start and LOAD.
    assign shift_en = ((state_reg == IDLE) && i_start) || (state_reg == LOAD);

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic [SIZE-1:0] word_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    word_reg <= '0;
                end else if (shift_en) begin
                    word_reg <= {word_reg[SIZE-NIBBLE_W-1:0], lane_nib[gi]};
                end
            end
        end
    endgenerate

    assign o_a     = g_lane[0].word_reg;
    assign o_prime = g_lane[1].word_reg;
    assign o_k     = g_lane[2].word_reg;
    assign o_px    = g_lane[3].word_reg;
    assign o_py    = g_lane[4].word_reg;

    assign prime_w = g_lane[1].word_reg;
    assign k_w     = g_lane[2].word_reg;
    assign px_w    = g_lane[3].word_reg;
    assign py_w    = g_lane[4].word_reg;

    // Rejection reasons in priority order: bad prime, point out of field, zero scalar.
    always_comb begin
        chk_code = 2'd0;
        if ((prime_w == '0) || !prime_w[0]) begin
            chk_code = 2'd1;
        end else if ((px_w >= prime_w) || (py_w >= prime_w)) begin
            chk_code = 2'd2;
        end else if (k_w == '0) begin
            chk_code = 2'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            valid_reg    <= 1'b0;
            err_reg      <= 1'b0;
            err_code_reg <= 2'd0;
        end else begin
            err_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (i_start) begin
                        cnt_reg   <= CNT_W'(1);
                        state_reg <= (NUM_NIB == 1) ? CHECK : LOAD;
                    end
                end
                LOAD: begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    if (cnt_reg == CNT_W'(NUM_NIB - 1)) begin
                        state_reg <= CHECK;
                    end
                end
                CHECK: begin
                    cnt_reg      <= '0;
                    err_code_reg <= chk_code;
                    if (chk_code != 2'd0) begin
                        err_reg   <= 1'b1;
                        state_reg <= IDLE;
                    end else begin
                        valid_reg <= 1'b1;
                        state_reg <= HOLD;
                    end
                end
                HOLD: begin
                    if (i_ready) begin
                        valid_reg <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign o_valid    = valid_reg;
    assign o_err      = err_reg;
    assign o_err_code = err_code_reg;
    assign o_busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_ecc_operand_loader.sv
// Directed bench for ecc_operand_loader: framing, MSB order, backpressure, rejects,
// mid-frame reset and back-to-back start handling.
module tb_ecc_operand_loader;

    logic        clk;
    logic        reset;
    logic        i_start;
    logic [3:0]  i_a, i_prime, i_k, i_px, i_py;
    logic        i_ready;
    logic [31:0] o_a, o_prime, o_k, o_px, o_py;
    logic        o_valid, o_busy, o_err;
    logic [1:0]  o_err_code;

    int checks;
    int failures;

    ecc_operand_loader dut (
        .clk       (clk),
        .reset     (reset),
        .i_start   (i_start),
        .i_a       (i_a),
        .i_prime   (i_prime),
        .i_k       (i_k),
        .i_px      (i_px),
        .i_py      (i_py),
        .i_ready   (i_ready),
        .o_a       (o_a),
        .o_prime   (o_prime),
        .o_k       (o_k),
        .o_px      (o_px),
        .o_py      (o_py),
        .o_valid   (o_valid),
        .o_busy    (o_busy),
        .o_err     (o_err),
        .o_err_code(o_err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] nib(input logic [31:0] w, input int n);
        return w[31-4*n -: 4];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_nibbles(input logic [31:0] a, input logic [31:0] p, input logic [31:0] k,
                               input logic [31:0] px, input logic [31:0] py, input int n);
        i_a = nib(a, n); i_prime = nib(p, n); i_k = nib(k, n);
        i_px = nib(px, n); i_py = nib(py, n);
    endtask

    // Drives E0..E7; returns 1 ns after E7 with i_start low.
    task automatic drive_frame(input logic [31:0] a, input logic [31:0] p, input logic [31:0] k,
                               input logic [31:0] px, input logic [31:0] py);
        for (int n = 0; n < 8; n++) begin
            i_start = (n == 0);
            set_nibbles(a, p, k, px, py, n);
            tick();
        end
        i_start = 1'b0;
    endtask

    task automatic check_words(input string tag, input logic [31:0] a, input logic [31:0] p,
                               input logic [31:0] k, input logic [31:0] px, input logic [31:0] py);
        checks++;
        if ({o_a, o_prime, o_k, o_px, o_py} !== {a, p, k, px, py}) begin
            failures++;
            $display("FAIL %s words: got a=%h p=%h k=%h px=%h py=%h want a=%h p=%h k=%h px=%h py=%h",
                     tag, o_a, o_prime, o_k, o_px, o_py, a, p, k, px, py);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; i_start = 1'b0; i_ready = 1'b0;
        i_a = 4'hF; i_prime = 4'hF; i_k = 4'hF; i_px = 4'hF; i_py = 4'hF;
        tick(); tick(); tick();
        checks++;
        if ({o_valid, o_busy, o_err, o_err_code} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got valid=%b busy=%b err=%b code=%0d want all 0",
                     o_valid, o_busy, o_err, o_err_code);
        end
        check_words("reset", 0, 0, 0, 0, 0);
        reset = 1'b0;
        tick();
        $display("test_reset done");
    endtask

    task automatic nominal_frame(input string tag);
        i_ready = 1'b1;
        drive_frame(32'h2, 32'h11, 32'h2, 32'h5, 32'h1);
        checks++;
        if (o_busy !== 1'b1 || o_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s pre_check: got busy=%b valid=%b want busy=1 valid=0", tag, o_busy, o_valid);
        end
        tick(); // E8
        checks++;
        if (o_valid !== 1'b1 || o_err !== 1'b0 || o_err_code !== 2'd0) begin
            failures++;
            $display("FAIL %s E8: got valid=%b err=%b code=%0d want valid=1 err=0 code=0",
                     tag, o_valid, o_err, o_err_code);
        end
        check_words(tag, 32'h2, 32'h11, 32'h2, 32'h5, 32'h1);
        tick(); // E9 accept
        checks++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_err !== 1'b0) begin
            failures++;
            $display("FAIL %s E9: got valid=%b busy=%b err=%b want 0 0 0", tag, o_valid, o_busy, o_err);
        end
        $display("%s frame done", tag);
    endtask

    task automatic test_nominal();
        nominal_frame("nominal");
    endtask

    task automatic test_msb_backpressure();
        i_ready = 1'b0;
        drive_frame(32'h0, 32'hFFFFFFFB, 32'hA5A5A5A5, 32'h12345678, 32'h1);
        tick(); // E8
        checks++;
        if (o_valid !== 1'b1) begin
            failures++;
            $display("FAIL msb valid: got %b want 1", o_valid);
        end
        check_words("msb", 32'h0, 32'hFFFFFFFB, 32'hA5A5A5A5, 32'h12345678, 32'h1);
        for (int c = 0; c < 20; c++) begin
            i_start = c[0];
            i_a = 4'(c); i_prime = 4'(c + 3); i_k = 4'hC; i_px = 4'(c + 7); i_py = 4'h9;
            tick();
            checks++;
            if (o_valid !== 1'b1 || o_err !== 1'b0 || o_busy !== 1'b1 ||
                {o_a, o_prime, o_k, o_px, o_py} !== {32'h0, 32'hFFFFFFFB, 32'hA5A5A5A5, 32'h12345678, 32'h1}) begin
                failures++;
                $display("FAIL hold cycle %0d: got valid=%b err=%b busy=%b prime=%h px=%h want valid=1 err=0 busy=1 prime=fffffffb px=12345678",
                         c, o_valid, o_err, o_busy, o_prime, o_px);
            end
        end
        i_start = 1'b0;
        i_ready = 1'b1;
        tick();
        checks++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL release: got valid=%b busy=%b want 0 0", o_valid, o_busy);
        end
        check_words("after_accept", 32'h0, 32'hFFFFFFFB, 32'hA5A5A5A5, 32'h12345678, 32'h1);
        $display("test_msb_backpressure done");
    endtask

    task automatic test_rejects();
        logic [31:0] tp [4] = '{32'h10, 32'h11, 32'h11, 32'h10};
        logic [31:0] tk [4] = '{32'h2,  32'h2,  32'h0,  32'h0};
        logic [31:0] tx [4] = '{32'h1,  32'h11, 32'h1,  32'h1};
        logic [1:0]  tc [4] = '{2'd1,   2'd2,   2'd3,   2'd1};
        i_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            drive_frame(32'h3, tp[t], tk[t], tx[t], 32'h1);
            tick(); // E8
            checks++;
            if (o_err !== 1'b1 || o_valid !== 1'b0 || o_err_code !== tc[t]) begin
                failures++;
                $display("FAIL reject %0d E8: got err=%b valid=%b code=%0d want err=1 valid=0 code=%0d",
                         t, o_err, o_valid, o_err_code, tc[t]);
            end
            tick();
            checks++;
            if (o_err !== 1'b0 || o_valid !== 1'b0 || o_busy !== 1'b0 || o_err_code !== tc[t]) begin
                failures++;
                $display("FAIL reject %0d E9: got err=%b valid=%b busy=%b code=%0d want 0 0 0 code=%0d",
                         t, o_err, o_valid, o_busy, o_err_code, tc[t]);
            end
            $display("reject %0d code=%0d", t, o_err_code);
        end
    endtask

    task automatic test_reset_mid();
        i_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            i_start = (n == 0);
            set_nibbles(32'h76543210, 32'h89ABCDEF, 32'h11111111, 32'h22222222, 32'h33333333, n);
            tick();
        end
        i_start = 1'b0;
        reset = 1'b1;
        tick();
        checks++;
        if ({o_valid, o_busy, o_err, o_err_code} !== 5'b0) begin
            failures++;
            $display("FAIL mid_reset ctrl: got valid=%b busy=%b err=%b code=%0d want all 0",
                     o_valid, o_busy, o_err, o_err_code);
        end
        check_words("mid_reset", 0, 0, 0, 0, 0);
        reset = 1'b0;
        nominal_frame("post_reset");
    endtask

    task automatic test_back_to_back();
        i_ready = 1'b1;
        drive_frame(32'h2, 32'h11, 32'h2, 32'h5, 32'h1);
        tick(); // E8
        checks++;
        if (o_valid !== 1'b1) begin
            failures++;
            $display("FAIL b2b first valid: got %b want 1", o_valid);
        end
        i_start = 1'b1;
        set_nibbles(32'h3, 32'h17, 32'h5, 32'h16, 32'h2, 0);
        tick(); // accept cycle, start must be ignored
        checks++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b accept: got valid=%b busy=%b want 0 0", o_valid, o_busy);
        end
        drive_frame(32'h3, 32'h17, 32'h5, 32'h16, 32'h2);
        tick();
        checks++;
        if (o_valid !== 1'b1 || o_err !== 1'b0) begin
            failures++;
            $display("FAIL b2b second: got valid=%b err=%b want 1 0", o_valid, o_err);
        end
        check_words("b2b", 32'h3, 32'h17, 32'h5, 32'h16, 32'h2);
        tick();
        checks++;
        if (o_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b second accept: got valid=%b want 0", o_valid);
        end
        $display("test_back_to_back done");
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_nominal();
        test_msb_backpressure();
        test_rejects();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
